// File: rtl/mem_responder_pkg.sv
// Shared types and derived widths for the Rd/Wr/Done memory responder.
package mem_responder_pkg;

  localparam int DEF_MISS_LAT  = 4;
  localparam int DEF_LINES     = 8;
  localparam int DEF_MEM_WORDS = 1024;

  // Counter width needed to hold MISS_LAT-1 (the count loaded on a miss)
  function automatic int cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

  localparam int IDX_W   = $clog2(DEF_LINES);
  localparam int TAG_W   = 15 - IDX_W;
  localparam int MADDR_W = $clog2(DEF_MEM_WORDS);
  localparam int CNT_W   = cnt_w(DEF_MISS_LAT);

  typedef enum logic {IDLE, MISS} state_t;

endpackage

// File: rtl/mem_responder_tagstore.sv
// Direct-mapped tag/data store: combinational lookup, one synchronous write port.
module mem_responder_tagstore #(
  parameter int LINES = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             hit,
  output logic [15:0]      rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] w_idx,
  input  logic [TAG_W-1:0] w_tag,
  input  logic [15:0]      w_data
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [15:0]      data [LINES];

  // Tags are never reset, so a cleared valid bit masks whatever they hold
  assign hit   = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign rdata = data[lk_idx];

  // Valid bits: cleared by reset, set on any line fill or write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    valid        <= '0;
    else if (we) valid[w_idx] <= 1'b1;
  end

  // Tag and data storage, no reset needed
  always_ff @(posedge clk) begin
    if (we) begin
      tags[w_idx] <= w_tag;
      data[w_idx] <= w_data;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Responder for the Rd/Wr/Done protocol: direct-mapped write-allocate cache
// over a word-addressed backing array with a fixed miss latency.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MISS_LAT  = DEF_MISS_LAT,
  parameter int LINES     = DEF_LINES,
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 15 - IW;
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = cnt_w(MISS_LAT);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [14:0]    l_addr;   // latched Addr[15:1]
  logic [15:0]    l_data;
  logic           l_rd, l_wr;

  logic [15:0]    mem [MEM_WORDS];
  logic [15:0]    mem_rdata;
  logic           mem_we;
  logic [AW-1:0]  mem_a;
  logic [15:0]    mem_d;

  logic           ts_hit, ts_we;
  logic [15:0]    ts_rdata, ts_data;
  logic [IW-1:0]  ts_idx;
  logic [TW-1:0]  ts_tag;

  logic           req, bad, fin;
  logic [IW-1:0]  a_idx, l_idx;
  logic [TW-1:0]  a_tag, l_tag;
  logic [AW-1:0]  a_word, l_word;

  logic           unused_dump;
  assign unused_dump = createdump;

  assign a_idx  = Addr[IW:1];
  assign a_tag  = Addr[15:IW+1];
  assign a_word = Addr[AW:1];
  assign l_idx  = l_addr[IW-1:0];
  assign l_tag  = l_addr[14:IW];
  assign l_word = l_addr[AW-1:0];

  assign req       = Rd | Wr;
  assign bad       = (Rd & Wr) | Addr[0];
  assign fin       = (state == MISS) && (cnt == CW'(1));
  assign mem_rdata = mem[l_word];

  mem_responder_tagstore #(.LINES(LINES), .IDX_W(IW), .TAG_W(TW)) u_tags (
    .clk    (clk),
    .rst    (rst),
    .lk_idx (a_idx),
    .lk_tag (a_tag),
    .hit    (ts_hit),
    .rdata  (ts_rdata),
    .we     (ts_we),
    .w_idx  (ts_idx),
    .w_tag  (ts_tag),
    .w_data (ts_data)
  );

  // Array write steering: IDLE write hit updates both in place; miss
  // completion fills the line (from memory on read, latched data on write)
  always_comb begin
    ts_we   = 1'b0;
    ts_idx  = a_idx;
    ts_tag  = a_tag;
    ts_data = DataIn;
    mem_we  = 1'b0;
    mem_a   = a_word;
    mem_d   = DataIn;
    if (fin) begin
      ts_we   = rst;
      ts_idx  = l_idx;
      ts_tag  = l_tag;
      ts_data = l_wr ? l_data : mem_rdata;
      mem_we  = rst & l_wr;
      mem_a   = l_word;
      mem_d   = l_data;
    end else if (state == IDLE && Wr && !bad && ts_hit) begin
      ts_we  = rst;
      mem_we = rst;
    end
  end

  // Backing array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_d;
  end

  // Request FSM with registered Done/err/CacheHit/Stall/DataOut
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      l_addr   <= '0;
      l_data   <= '0;
      l_rd     <= 1'b0;
      l_wr     <= 1'b0;
      Done     <= 1'b0;
      err      <= 1'b0;
      CacheHit <= 1'b0;
      Stall    <= 1'b0;
      DataOut  <= '0;
    end else begin
      Done     <= 1'b0;
      err      <= 1'b0;
      CacheHit <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (bad) begin
              Done <= 1'b1;
              err  <= 1'b1;
            end else if (ts_hit) begin
              Done     <= 1'b1;
              CacheHit <= 1'b1;
              if (Rd) DataOut <= ts_rdata;
            end else begin
              l_addr <= Addr[15:1];
              l_data <= DataIn;
              l_rd   <= Rd;
              l_wr   <= Wr;
              cnt    <= CW'(MISS_LAT - 1);
              Stall  <= 1'b1;
              state  <= MISS;
            end
          end
        end
        MISS: begin
          if (fin) begin
            Done  <= 1'b1;
            Stall <= 1'b0;
            state <= IDLE;
            if (l_rd) DataOut <= mem_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: directed plan plus random traffic against a
// transaction-level cache/memory model.
module tb_mem_responder;

  localparam int LAT = 4;
  localparam int LINES = 8;
  localparam int MW = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn;
  logic        Rd, Wr, createdump;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err;

  mem_responder #(.MISS_LAT(LAT), .LINES(LINES), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: memory words, per-line valid/tag/data, expected DataOut
  logic [15:0] mmem [MW];
  bit          mwr [MW];
  bit          cv [LINES];
  int          ctag [LINES];
  logic [15:0] cdat [LINES];
  logic [15:0] exp_do;
  logic [15:0] park_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request: drive for one cycle, park inputs, check every cycle to Done
  task automatic req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    int idx = int'(a[3:1]);
    int tg  = int'(a[15:4]);
    int w   = int'(a[10:1]);
    bit bad = (rd && wr) || a[0];
    bit hit = !bad && cv[idx] && (ctag[idx] == tg);
    int lat = (bad || hit) ? 1 : LAT;
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    @(posedge clk); #1;
    Rd = 0; Wr = 0; Addr = park_addr; DataIn = 16'($urandom);
    if (!bad) begin
      if (wr) begin mmem[w] = d; mwr[w] = 1; end
      if (!hit) begin cv[idx] = 1; ctag[idx] = tg; cdat[idx] = mmem[w]; end
      else if (wr) cdat[idx] = d;
      if (rd) exp_do = cdat[idx];
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) begin
        chk("busy_done", Done, 0);
        chk("busy_stall", Stall, 1);
      end else begin
        chk("done", Done, 1);
        chk("stall_end", Stall, 0);
        chk("cachehit", CacheHit, hit);
        chk("err", err, bad);
        chk("dataout", DataOut, exp_do);
      end
    end
  endtask

  task automatic idle_cycle();
    Rd = 0; Wr = 0;
    @(negedge clk);
    chk("idle_done", Done, 0);
    chk("idle_stall", Stall, 0);
    chk("idle_hit", CacheHit, 0);
    chk("idle_err", err, 0);
  endtask

  // Back-to-back reads with Rd held high across edges
  task automatic stream(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
    logic [15:0] as [3];
    as[0] = a0; as[1] = a1; as[2] = a2;
    Rd = 1; Wr = 0;
    for (int i = 0; i < 3; i++) begin
      int idx = int'(as[i][3:1]);
      bit hit = cv[idx] && (ctag[idx] == int'(as[i][15:4]));
      Addr = as[i];
      @(posedge clk); #1;
      if (i == 2) Rd = 0;
      @(negedge clk);
      exp_do = cdat[idx];
      chk("stream_done", Done, 1);
      chk("stream_hit", CacheHit, hit);
      chk("stream_stall", Stall, 0);
      chk("stream_data", DataOut, exp_do);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0; Rd = 0; Wr = 0; Addr = 0; DataIn = 0; createdump = 0;
    park_addr = 16'h0002;
    exp_do = 16'h0000;
    for (int i = 0; i < LINES; i++) cv[i] = 0;
    for (int i = 0; i < MW; i++) mwr[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst_done", Done, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_hit", CacheHit, 0);
    chk("rst_err", err, 0);
    chk("rst_data", DataOut, 16'h0000);
    rst = 1;
    idle_cycle();

    // Write miss then read hit
    req(0, 1, 16'h0010, 16'hBEEF);
    req(1, 0, 16'h0010, 16'h0000);
    // Conflict eviction on line 0
    req(0, 1, 16'h0030, 16'h1234);
    req(1, 0, 16'h0010, 16'h0000);
    req(1, 0, 16'h0030, 16'h0000);
    // Error requests leave arrays untouched
    req(1, 0, 16'h0011, 16'h0000);
    req(1, 1, 16'h0010, 16'h5555);
    req(1, 0, 16'h0010, 16'h0000);
    idle_cycle();
    // Three consecutive hits
    req(0, 1, 16'h0002, 16'h1111);
    req(0, 1, 16'h0004, 16'h2222);
    stream(16'h0010, 16'h0002, 16'h0004);
    // Inputs change while a miss is in flight
    req(0, 1, 16'h0040, 16'hCAFE);
    req(1, 0, 16'h0010, 16'h0000);
    park_addr = 16'h0002;
    req(1, 0, 16'h0040, 16'h0000);
    req(1, 0, 16'h0002, 16'h0000);

    // Reset in the middle of a write miss: no Done, no array write
    Rd = 0; Wr = 1; Addr = 16'h0010; DataIn = 16'hDEAD;
    @(posedge clk); #1;
    Wr = 0;
    @(negedge clk);
    chk("abort_stall_pre", Stall, 1);
    @(posedge clk); #1;
    rst = 0;
    #1;
    exp_do = 16'h0000;
    for (int i = 0; i < LINES; i++) cv[i] = 0;
    chk("abort_stall", Stall, 0);
    chk("abort_done", Done, 0);
    chk("abort_data", DataOut, exp_do);
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      chk("abort_no_done", Done, 0);
    end
    rst = 1;
    idle_cycle();
    req(1, 0, 16'h0010, 16'h0000);

    // Random traffic over a small aliased address pool
    for (int n = 0; n < 300; n++) begin
      int sel = $urandom_range(0, 99);
      logic [15:0] a;
      a = {3'b000, 2'($urandom_range(0, 3)), 5'b00000, 5'($urandom_range(0, 31)), 1'b0};
      park_addr = 16'($urandom);
      if (sel < 10) idle_cycle();
      else if (sel < 15) req(1, 0, a | 16'h0001, 16'($urandom));
      else if (sel < 20) req(1, 1, a, 16'($urandom));
      else if (sel < 55 || !mwr[int'(a[10:1])]) req(0, 1, a, 16'($urandom));
      else req(1, 0, a, 16'h0000);
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
